hazard_sb: RTL

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb_if.sv | 50 +++++
 rtl/hazard_sb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_sb_if.sv
// Pipeline-side bundle for the hazard/scoreboard unit: stage registers and
// controls in, stall/flush/forward/redirect controls out.
interface hazard_sb_if #(
    parameter int AW = 5
);
    logic [AW-1:0] rsD, rtD;
    logic          branchD, jrD, latD;
    logic [AW-1:0] rsE, rtE, writeregE;
    logic          regwriteE, memtoregE, readcp0E;
    logic          lat_issueE;
    logic [AW-1:0] writeregM;
    logic          regwriteM, memtoregM, readcp0M;
    logic [31:0]   excepttypeM, epc_oM;
    logic [AW-1:0] writeregW;
    logic          regwriteW;
    logic          lat_doneW;
    logic          stallreq_from_if, stallreq_from_mem;

    logic          stallF, stallD, stallE, stallM;
    logic          flushF, flushD, flushE, flushM, flushW;
    logic          forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic [31:0]   except_pc;
    logic          redirect, kill_lat;
    logic          sb_full;

    modport master (
        output rsD, rtD, branchD, jrD, latD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, readcp0E, lat_issueE,
        output writeregM, regwriteM, memtoregM, readcp0M, excepttypeM, epc_oM,
        output writeregW, regwriteW, lat_doneW,
        output stallreq_from_if, stallreq_from_mem,
        input  stallF, stallD, stallE, stallM,
        input  flushF, flushD, flushE, flushM, flushW,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  except_pc, redirect, kill_lat, sb_full
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, latD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, readcp0E, lat_issueE,
        input  writeregM, regwriteM, memtoregM, readcp0M, excepttypeM, epc_oM,
        input  writeregW, regwriteW, lat_doneW,
        input  stallreq_from_if, stallreq_from_mem,
        output stallF, stallD, stallE, stallM,
        output flushF, flushD, flushE, flushM, flushW,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output except_pc, redirect, kill_lat, sb_full
    );
endinterface

// File: rtl/hazard_sb.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls, a register
// scoreboard for long-latency ops, and the exception redirect sequencer.
module hazard_sb #(
    parameter int          AW        = 5,
    parameter int          MAX_PEND  = 2,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000e
) (
    input logic       clk,
    input logic       rst,
    hazard_sb_if.slave sb
);
    localparam int             CW      = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_PEND);
    localparam logic [CW-1:0]  ONE     = CW'(1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0]         state, nextState;
    logic [2**AW-1:0]   pending, pendNext;
    logic [CW-1:0]      count, countNext;
    logic [31:0]        exceptPc;
    logic               sbFull, excIn, issueOk, doneOk;
    logic               lwStall, branchStall, sbStall, decodeHazard;
    logic               eHitRs, eHitRt, mHitRs, mHitRt;
    logic [1:0]         fwdAE, fwdBE;
    logic               fwdAD, fwdBD;
    logic               stallF, stallD, stallE, stallM;
    logic               flushF, flushD, flushE, flushM, flushW;
    logic               redirect, killLat;

    assign sbFull = (count == MAX_CNT);
    assign excIn  = (state == RUN) && (sb.excepttypeM != '0);

    // Forwarding: the younger producer in M takes priority over W.
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (sb.rsE != '0 && sb.rsE == sb.writeregM && sb.regwriteM)      fwdAE = 2'b10;
        else if (sb.rsE != '0 && sb.rsE == sb.writeregW && sb.regwriteW) fwdAE = 2'b01;
        if (sb.rtE != '0 && sb.rtE == sb.writeregM && sb.regwriteM)      fwdBE = 2'b10;
        else if (sb.rtE != '0 && sb.rtE == sb.writeregW && sb.regwriteW) fwdBE = 2'b01;
        fwdAD = (sb.rsD != '0) && (sb.rsD == sb.writeregM) && sb.regwriteM;
        fwdBD = (sb.rtD != '0) && (sb.rtD == sb.writeregM) && sb.regwriteM;
    end

    always_comb begin
        lwStall = (sb.rtE != '0) && (sb.rsD == sb.rtE || sb.rtD == sb.rtE)
                  && (sb.memtoregE || sb.readcp0E);
        eHitRs = sb.regwriteE && (sb.writeregE != '0) && (sb.writeregE == sb.rsD);
        eHitRt = sb.regwriteE && (sb.writeregE != '0) && (sb.writeregE == sb.rtD);
        mHitRs = (sb.memtoregM || sb.readcp0M) && (sb.writeregM != '0) && (sb.writeregM == sb.rsD);
        mHitRt = (sb.memtoregM || sb.readcp0M) && (sb.writeregM != '0) && (sb.writeregM == sb.rtD);
        branchStall = (sb.branchD && (eHitRs || eHitRt || mHitRs || mHitRt))
                      || (sb.jrD && (eHitRs || mHitRs));
        sbStall = pending[sb.rsD] || pending[sb.rtD] || (sb.latD && sbFull);
        decodeHazard = lwStall || branchStall || sbStall;
    end

    // Stage controls; everything is held quiet while reset is asserted.
    always_comb begin
        stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
        flushF = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
        redirect = 1'b0;
        killLat  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (excIn) begin
                        stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
                        flushW = 1'b1;
                    end else begin
                        stallF = decodeHazard || sb.stallreq_from_if || sb.stallreq_from_mem;
                        stallD = stallF;
                        flushE = (decodeHazard || sb.stallreq_from_if) && !sb.stallreq_from_mem;
                        stallE = sb.stallreq_from_mem;
                        stallM = sb.stallreq_from_mem;
                        flushW = sb.stallreq_from_mem;
                    end
                end
                WAIT_MEM: begin
                    stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
                end
                FLUSH: begin
                    flushF = 1'b1; flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
                    redirect = 1'b1;
                    killLat  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = RUN;
        case (state)
            RUN:      nextState = excIn ? (sb.stallreq_from_mem ? WAIT_MEM : FLUSH) : RUN;
            WAIT_MEM: nextState = sb.stallreq_from_mem ? WAIT_MEM : FLUSH;
            default:  nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            exceptPc <= '0;
        end else begin
            state <= nextState;
            if (excIn)
                exceptPc <= (sb.excepttypeM == ERET_CODE) ? sb.epc_oM : EXC_VEC;
        end
    end

    // Scoreboard: a done clears first so a same-register issue wins the bit.
    always_comb begin
        issueOk   = sb.lat_issueE && (state != FLUSH) && !sbFull && (sb.writeregE != '0);
        doneOk    = sb.lat_doneW && (state != FLUSH) && pending[sb.writeregW];
        pendNext  = pending;
        countNext = count;
        if (doneOk)  pendNext[sb.writeregW] = 1'b0;
        if (issueOk) pendNext[sb.writeregE] = 1'b1;
        if (issueOk && !doneOk)      countNext = count + ONE;
        else if (!issueOk && doneOk) countNext = count - ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else if (state == FLUSH) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pendNext;
            count   <= countNext;
        end
    end

    assign sb.stallF    = stallF;
    assign sb.stallD    = stallD;
    assign sb.stallE    = stallE;
    assign sb.stallM    = stallM;
    assign sb.flushF    = flushF;
    assign sb.flushD    = flushD;
    assign sb.flushE    = flushE;
    assign sb.flushM    = flushM;
    assign sb.flushW    = flushW;
    assign sb.forwardaE = rst ? 2'b00 : fwdAE;
    assign sb.forwardbE = rst ? 2'b00 : fwdBE;
    assign sb.forwardaD = !rst && fwdAD;
    assign sb.forwardbD = !rst && fwdBD;
    assign sb.except_pc = exceptPc;
    assign sb.redirect  = redirect;
    assign sb.kill_lat  = killLat;
    assign sb.sb_full   = sbFull;
endmodule
